// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame constants and
// well-known host command codes.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RTS,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } ps2_tx_state_e;

  localparam int          PS2_DATA_BITS   = 8;
  localparam logic [7:0]  PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0]  PS2_CMD_RESET   = 8'hFF;

  // Odd parity: ones over data plus this bit always total an odd number.
  function automatic logic ps2_odd_parity(input logic [PS2_DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command/result handshake plus the open-drain PS/2 pin pair of the
// host transmitter, bundled for the user side (master) and the block (slave).
interface ps2_host_tx_if;
  logic       wr_ps2;
  logic [7:0] din;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       ack_err;

  modport master (
    output wr_ps2, din, ps2c_in, ps2d_in,
    input  ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err
  );

  modport slave (
    input  wr_ps2, din, ps2c_in, ps2d_in,
    output ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err
  );
endinterface

// File: rtl/ps2_edge_filter.sv
// Two-flop synchroniser, FILTER_LEN-deep glitch filter and registered
// falling-edge tick for one PS/2 line (lines idle high).
module ps2_edge_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fall_q;

    // Count consecutive samples that disagree with the filtered level;
    // any agreeing sample restarts the run.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin_i};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            fall_q <= filt_q & ~filt_d;
        end
    end

    assign level_o = filt_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send inhibit, byte shifted out
// on device clock falls with odd parity, device ack check and frame timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  bus
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_tx_state_e            state_q, state_d;
    logic [PS2_DATA_BITS-1:0] sh_q, sh_d;
    logic                     par_q, par_d;
    logic [2:0]               bit_q, bit_d;
    logic [IW-1:0]            inh_q, inh_d;
    logic [TW-1:0]            to_q, to_d;
    logic                     c_oe_q, c_oe_d;
    logic                     d_oe_q, d_oe_d;
    logic                     idle_q, idle_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic c_level, c_fall, d_level;
    logic unused_d_fall;

    ps2_edge_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (bus.ps2c_in),
        .level_o (c_level),
        .fall_o  (c_fall)
    );

    ps2_edge_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (bus.ps2d_in),
        .level_o (d_level),
        .fall_o  (unused_d_fall)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        par_d   = par_q;
        bit_d   = bit_q;
        inh_d   = inh_q;
        to_d    = to_q;
        c_oe_d  = c_oe_q;
        d_oe_d  = d_oe_q;
        idle_d  = idle_q;
        done_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.wr_ps2) begin
                    sh_d    = bus.din;
                    par_d   = ps2_odd_parity(bus.din);
                    err_d   = 1'b0;
                    idle_d  = 1'b0;
                    inh_d   = '0;
                    c_oe_d  = 1'b1;
                    state_d = ST_RTS;
                end
            end
            ST_RTS: begin
                // Releasing clock and pulling data in the same cycle is the
                // request-to-send the device answers by clocking.
                if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b1;
                    to_d    = '0;
                    state_d = ST_START;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            ST_START: begin
                if (c_fall) begin
                    d_oe_d  = ~sh_q[0];
                    sh_d    = sh_q >> 1;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // bit_q counts d1..d7 already presented; the fall after d7 shows parity.
                if (c_fall) begin
                    if (bit_q == 3'(PS2_DATA_BITS - 1)) begin
                        d_oe_d  = ~par_q;
                        state_d = ST_PARITY;
                    end else begin
                        d_oe_d = ~sh_q[0];
                        sh_d   = sh_q >> 1;
                        bit_d  = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (c_fall) begin
                    d_oe_d  = 1'b0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (c_fall) begin
                    err_d   = d_level;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (c_level && d_level) begin
                    done_d  = 1'b1;
                    idle_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A silent device aborts the frame from any clocked phase.
        if (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) begin
            if (c_fall) begin
                to_d = '0;
            end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                c_oe_d  = 1'b0;
                d_oe_d  = 1'b0;
                err_d   = 1'b1;
                done_d  = 1'b1;
                idle_d  = 1'b1;
                to_d    = '0;
                state_d = ST_IDLE;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            inh_q   <= '0;
            to_q    <= '0;
            c_oe_q  <= 1'b0;
            d_oe_q  <= 1'b0;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            bit_q   <= bit_d;
            inh_q   <= inh_d;
            to_q    <= to_d;
            c_oe_q  <= c_oe_d;
            d_oe_q  <= d_oe_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.ps2c_oe      = c_oe_q;
    assign bus.ps2d_oe      = d_oe_q;
    assign bus.tx_idle      = idle_q;
    assign bus.tx_done_tick = done_q;
    assign bus.ack_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a clocking/acking device model,
// frame expectations derived from the byte, and a per-cycle output monitor.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 300;
    localparam int TO  = 1500;
    localparam int FL  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ps2_host_tx_if bus ();

    logic dev_c_low = 1'b0;
    logic dev_d_low = 1'b0;
    assign bus.ps2c_in = ~(bus.ps2c_oe | dev_c_low);
    assign bus.ps2d_in = ~(bus.ps2d_oe | dev_d_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;
    bit mdl_ack  = 1'b0;
    bit prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Wire order after the start bit: d0..d7, odd parity, stop (released = 1).
    function automatic logic [10:1] frame_of(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    // Output monitor: idle means both lines released and the last result held.
    always @(negedge clk) begin
        if (bus.tx_idle)
            chk("idle_outputs", {29'd0, bus.ps2c_oe, bus.ps2d_oe, bus.ack_err}, {31'd0, mdl_ack});
        if (bus.tx_done_tick) begin
            done_cnt++;
            chk("done_with_idle", bus.tx_idle, 1);
            chk("done_ack_err", bus.ack_err, mdl_ack);
            chk("done_one_cycle", prev_done, 0);
        end
        prev_done = bus.tx_done_tick;
    end

    task automatic run_frame(input logic [7:0] d, input int H, input bit ack, input int stop_k,
                             input int glitch_k, input int busy_k, input int rst_k,
                             output logic [10:1] cap);
        logic [10:1] exp_f;
        bit   exp_err;
        int   n, base, last, gap, lim;
        bit   seen;
        exp_f   = frame_of(d);
        exp_err = (stop_k != 0) || !ack;
        cap     = '0;

        @(posedge clk); #1 bus.din = d; bus.wr_ps2 = 1'b1;
        @(posedge clk); #1 bus.wr_ps2 = 1'b0; bus.din = 8'($urandom); mdl_ack = exp_err;
        base = done_cnt;

        n = 0;
        for (int i = 0; i < INH + 20; i++) begin
            @(negedge clk);
            if (!bus.ps2c_oe) break;
            n++;
        end
        chk("rts_length", n, INH);
        chk("rts_data_rises", bus.ps2d_oe, 1);
        chk("start_bit_low", bus.ps2d_in, 0);

        repeat (H) @(posedge clk);
        #1;
        for (int k = 1; k <= 11; k++) begin
            for (int c = 0; c < H; c++) begin
                @(posedge clk); #1;
                if (c == 0) dev_c_low = 1'b1;
                if (k == rst_k && c == H - 2) begin
                    #2 rst = 1'b0; mdl_ack = 1'b0;
                    #1;
                    chk("rst_c_oe_drop", bus.ps2c_oe, 0);
                    chk("rst_d_oe_drop", bus.ps2d_oe, 0);
                    chk("rst_idle", bus.tx_idle, 1);
                end
                if (c == H - 1 && k <= 10 && k != rst_k) cap[k] = bus.ps2d_in;
            end
            if (k == rst_k || k == stop_k || k == 11) begin
                dev_c_low = 1'b0;
                dev_d_low = 1'b0;
                break;
            end
            dev_c_low = 1'b0;
            for (int c = 0; c < H; c++) begin
                @(posedge clk); #1;
                if (k == 10 && ack && c == 2) dev_d_low = 1'b1;
                if (k == glitch_k) dev_c_low = (c >= H - 12 && c < H - 9);
                if (k == busy_k && c == 3) begin bus.din = PS2_CMD_RESET; bus.wr_ps2 = 1'b1; end
                if (k == busy_k && c == 4) bus.wr_ps2 = 1'b0;
            end
        end

        if (rst_k != 0) begin
            for (int i = 1; i < rst_k; i++) chk($sformatf("frame_bit%0d", i), cap[i], exp_f[i]);
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;
            repeat (40) @(negedge clk);
            chk("no_done_after_reset", done_cnt - base, 0);
            chk("idle_after_reset", bus.tx_idle, 1);
        end else begin
            last = (stop_k != 0) ? stop_k : 10;
            for (int i = 1; i <= last; i++) chk($sformatf("frame_bit%0d", i), cap[i], exp_f[i]);
            lim  = (stop_k != 0) ? TO + FL + 100 : 300;
            gap  = 0;
            seen = 1'b0;
            for (int i = 0; i < lim; i++) begin
                @(negedge clk);
                if (bus.tx_done_tick) begin seen = 1'b1; break; end
                gap++;
            end
            chk("done_seen", seen, 1);
            chk("done_lines_released", {bus.ps2c_oe, bus.ps2d_oe}, 0);
            chk("done_ack_err_value", bus.ack_err, exp_err);
            if (stop_k != 0)
                chk("timeout_gap", (H - 1 + gap >= TO + FL) && (H - 1 + gap <= TO + FL + 6), 1);
            repeat (5) @(negedge clk);
            chk("single_done", done_cnt - base, 1);
        end
    endtask

    initial begin
        logic [10:1] cap;
        bus.wr_ps2 = 1'b0;
        bus.din    = '0;
        rst        = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_c_oe", bus.ps2c_oe, 0);
        chk("reset_d_oe", bus.ps2d_oe, 0);
        chk("reset_idle", bus.tx_idle, 1);
        chk("reset_done", bus.tx_done_tick, 0);
        chk("reset_ack_err", bus.ack_err, 0);

        // Write while reset is held must not start anything.
        @(posedge clk); #1 bus.wr_ps2 = 1'b1; bus.din = PS2_CMD_SET_LED;
        @(posedge clk); #1 bus.wr_ps2 = 1'b0;
        #2 rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_beats_write_idle", bus.tx_idle, 1);
        chk("reset_beats_write_c_oe", bus.ps2c_oe, 0);

        run_frame(PS2_CMD_SET_LED, 20, 1'b1, 0, 0, 0, 0, cap);
        chk("literal_frame_ED", cap, 10'h3ED);
        run_frame(8'h01, 20, 1'b1, 0, 0, 0, 0, cap);
        chk("literal_parity_01", cap[9], 0);
        run_frame(8'h00, 18, 1'b1, 0, 0, 0, 0, cap);
        chk("literal_parity_00", cap[9], 1);
        run_frame(8'h5A, 22, 1'b0, 0, 0, 0, 0, cap);
        run_frame(8'h3C, 20, 1'b1, 4, 0, 0, 0, cap);
        run_frame(8'h12, 24, 1'b1, 0, 0, 4, 0, cap);
        run_frame(8'hA5, 30, 1'b1, 0, 5, 0, 0, cap);
        run_frame(8'h96, 20, 1'b1, 0, 0, 0, 5, cap);
        for (int r = 0; r < 8; r++)
            run_frame(8'($urandom), int'($urandom_range(16, 35)), ($urandom_range(0, 4) != 0),
                      0, 0, 0, 0, cap);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit (tests %0d, failed %0d)", tests, fails);
        $fatal(1);
    end

endmodule
